// File: rtl/clk_monitor_pkg.sv
// Shared constants, FSM encoding and helpers for the clk_slow period monitor.
package clk_monitor_pkg;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_TIMEOUT     = 1024;
  localparam int unsigned DEF_LOCK_COUNT  = 4;
  localparam int unsigned DEF_TOL         = 1;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_LOST    = 2'd3;

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/clk_monitor_if.sv
// Slow-clock input and measurement/status outputs of the clock monitor.
interface clk_monitor_if
  import clk_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             clk_slow;
  logic             rise_tick;
  logic             fall_tick;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             clk_lost;

  modport master (
    input  clk_slow,
    output rise_tick,
    output fall_tick,
    output period,
    output period_valid,
    output locked,
    output clk_lost
  );

  modport slave (
    output clk_slow,
    input  rise_tick,
    input  fall_tick,
    input  period,
    input  period_valid,
    input  locked,
    input  clk_lost
  );

endinterface

// File: rtl/clk_monitor_sync_edge.sv
// Synchronizer chain plus edge-history flop; rise/fall are registered one-cycle pulses.
module sync_edge
  import clk_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & hist_q;
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clk_monitor.sv
// Measures the clk_slow period in clkin cycles, tracks lock on a stable period
// and flags loss of clk_slow after TIMEOUT cycles without a rising edge.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int unsigned TOL         = DEF_TOL
) (
  input  logic              clkin,
  input  logic              rst_n,
  clk_monitor_if.master     mon
);

  localparam int unsigned   MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_COUNT);

  logic             rise;
  logic             fall;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] prev_q,   prev_d;
  logic [MW-1:0]    match_q,  match_d;
  logic             pv_q,     pv_d;
  logic             rise_tick_q;
  logic             fall_tick_q;

  logic             in_tol;
  logic             timeout;
  logic [MW-1:0]    match_inc;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clkin (clkin),
    .rst_n (rst_n),
    .din   (mon.clk_slow),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    in_tol    = abs_diff(32'(cnt_q), 32'(prev_q)) <= TOL;
    timeout   = (cnt_q == TIMEOUT_C);
    match_inc = (match_q == LOCK_C) ? match_q : match_q + 1'b1;
  end

  // rise is evaluated ahead of timeout everywhere so a coincident edge keeps the clock alive
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    prev_d   = prev_q;
    match_d  = match_q;
    pv_d     = 1'b0;

    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (state_q != ST_LOST && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else if (timeout) begin
          state_d = ST_LOST;
          match_d = '0;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          pv_d     = 1'b1;
          period_d = cnt_q;
          prev_d   = cnt_q;
          match_d  = in_tol ? match_inc : '0;
        end else if (timeout) begin
          state_d = ST_LOST;
          match_d = '0;
        end else if (match_q == LOCK_C) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          pv_d     = 1'b1;
          period_d = cnt_q;
          prev_d   = cnt_q;
          if (in_tol) begin
            match_d = match_inc;
          end else begin
            state_d = ST_MEASURE;
            match_d = '0;
          end
        end else if (timeout) begin
          state_d = ST_LOST;
          match_d = '0;
        end
      end
      default: begin
        // Recovery restarts measurement from scratch: first period compares against 0
        match_d = '0;
        if (rise) begin
          state_d = ST_MEASURE;
          prev_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      prev_q      <= '0;
      match_q     <= '0;
      pv_q        <= 1'b0;
      rise_tick_q <= 1'b0;
      fall_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      pv_q        <= pv_d;
      rise_tick_q <= rise;
      fall_tick_q <= fall;
    end
  end

  assign mon.rise_tick    = rise_tick_q;
  assign mon.fall_tick    = fall_tick_q;
  assign mon.period       = period_q;
  assign mon.period_valid = pv_q;
  assign mon.locked       = (state_q == ST_LOCKED);
  assign mon.clk_lost     = (state_q == ST_LOST);

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: table of slow-clock phases plus hand sequences.
module tb_clk_monitor;
  import clk_monitor_pkg::*;

  logic clkin = 1'b0;
  logic rst_n = 1'b0;

  clk_monitor_if #(.CNT_W(16)) mon ();

  clk_monitor #(
    .SYNC_STAGES (2),
    .CNT_W       (16),
    .TIMEOUT     (64),
    .LOCK_COUNT  (4),
    .TOL         (1)
  ) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .mon   (mon)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int hi_a; int lo_a; int hi_b; int lo_b; int n;
    int exp_pv; int exp_last; int exp_locked; int exp_rose; int exp_fell; int exp_drop;
  } row_t;

  row_t rows [4];

  int checks = 0;
  int errors = 0;

  int sidx = 0;
  int base;
  int first_rise, first_fall, first_pv, first_pv_period;
  int pv_at_first_rise, lost_at_first_rise;
  int lock_idx, pv_at_lock;
  int pv_cnt, last_period, rose_cnt, fell_cnt, drop_period;
  int lost_seen, lost_rise_idx, last_rise_idx;
  logic prev_locked = 1'b0;
  logic prev_lost   = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    first_rise = -1; first_fall = -1; first_pv = -1; first_pv_period = -1;
    pv_at_first_rise = -1; lost_at_first_rise = -1;
    lock_idx = -1; pv_at_lock = -1;
    pv_cnt = 0; rose_cnt = 0; fell_cnt = 0; drop_period = -1;
    lost_seen = 0; lost_rise_idx = -1;
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
    sidx++;
    if (mon.rise_tick === 1'b1) begin
      last_rise_idx = sidx;
      if (first_rise < 0) begin
        first_rise         = sidx;
        pv_at_first_rise   = int'(mon.period_valid);
        lost_at_first_rise = int'(mon.clk_lost);
      end
    end
    if (mon.fall_tick === 1'b1 && first_fall < 0) first_fall = sidx;
    if (mon.period_valid === 1'b1) begin
      pv_cnt++;
      last_period = int'(mon.period);
      if (first_pv < 0) begin
        first_pv        = sidx;
        first_pv_period = int'(mon.period);
      end
    end
    if (mon.locked === 1'b1 && !prev_locked) begin
      rose_cnt++;
      if (lock_idx < 0) begin
        lock_idx   = sidx;
        pv_at_lock = pv_cnt;
      end
    end
    if (mon.locked !== 1'b1 && prev_locked) begin
      fell_cnt++;
      if (drop_period < 0) drop_period = int'(mon.period);
    end
    if (mon.clk_lost === 1'b1 && !prev_lost) begin
      lost_seen++;
      lost_rise_idx = sidx;
    end
    prev_locked = (mon.locked === 1'b1);
    prev_lost   = (mon.clk_lost === 1'b1);
  endtask

  task automatic run_period(input int hi, input int lo);
    for (int i = 0; i < hi; i++) begin mon.clk_slow = 1'b1; tick(); end
    for (int i = 0; i < lo; i++) begin mon.clk_slow = 1'b0; tick(); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mon.clk_slow = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{4, 4, 4, 4,  8,  7,  8, 1, 1, 0, -1};
    rows[1] = '{8, 8, 8, 8,  8,  8, 16, 1, 1, 1, 16};
    rows[2] = '{4, 4, 4, 5, 10, 10,  8, 1, 1, 1,  8};
    rows[3] = '{4, 4, 5, 6, 12, 12,  8, 0, 0, 1, 11};
    last_rise_idx = -1;
    last_period   = -1;
    clear_log();

    // Reset state
    do_reset();
    check("reset_rise_tick",    mon.rise_tick,    0);
    check("reset_fall_tick",    mon.fall_tick,    0);
    check("reset_period",       mon.period,       0);
    check("reset_period_valid", mon.period_valid, 0);
    check("reset_locked",       mon.locked,       0);
    check("reset_clk_lost",     mon.clk_lost,     0);

    // clkin/2: edge latency, first rise without period_valid, lock after 5 periods
    clear_log();
    base  = sidx + 1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) run_period(1, 1);
    check("div2_rise_latency",    first_rise - base, 3);
    check("div2_fall_latency",    first_fall - base, 4);
    check("div2_first_rise_pv",   pv_at_first_rise,  0);
    check("div2_first_pv_idx",    first_pv - base,   5);
    check("div2_first_period",    first_pv_period,   2);
    check("div2_lock_idx",        lock_idx - base,   14);
    check("div2_pv_at_lock",      pv_at_lock,        5);
    check("div2_last_period",     last_period,       2);

    // Table of slow-clock phases, continuous waveform from a fresh reset
    do_reset();
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      clear_log();
      for (int k = 0; k < rows[r].n; k++) begin
        if (k % 2 == 0) run_period(rows[r].hi_a, rows[r].lo_a);
        else            run_period(rows[r].hi_b, rows[r].lo_b);
      end
      check($sformatf("row%0d_pv_count", r),    pv_cnt,        rows[r].exp_pv);
      check($sformatf("row%0d_last_period", r), last_period,   rows[r].exp_last);
      check($sformatf("row%0d_locked", r),      mon.locked,    rows[r].exp_locked);
      check($sformatf("row%0d_lock_rose", r),   rose_cnt,      rows[r].exp_rose);
      check($sformatf("row%0d_lock_fell", r),   fell_cnt,      rows[r].exp_fell);
      check($sformatf("row%0d_drop_period", r), drop_period,   rows[r].exp_drop);
      check($sformatf("row%0d_clk_lost", r),    mon.clk_lost,  0);
    end

    // Rise arriving exactly at the timeout count keeps the clock alive
    clear_log();
    run_period(4, 60);
    run_period(4, 4);
    check("tie_no_lost",     lost_seen,   0);
    check("tie_period",      last_period, 64);

    // Stop clk_slow: lost exactly TIMEOUT cycles after the last rise_tick
    clear_log();
    mon.clk_slow = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("lost_delay",       lost_rise_idx - last_rise_idx, 64);
    check("lost_level",       mon.clk_lost, 1);
    check("lost_locked",      mon.locked,   0);
    check("lost_period_hold", mon.period,   64);
    check("lost_no_pv",       pv_cnt,       0);

    // Restart: first rise clears clk_lost without a period_valid
    clear_log();
    for (int i = 0; i < 3; i++) run_period(4, 4);
    check("recover_lost_at_rise", lost_at_first_rise, 0);
    check("recover_pv_at_rise",   pv_at_first_rise,   0);
    check("recover_first_period", first_pv_period,    8);
    check("recover_pv_count",     pv_cnt,             2);

    // Reset pulse while locked
    for (int i = 0; i < 6; i++) run_period(4, 4);
    check("prereset_locked", mon.locked, 1);
    mon.clk_slow = 1'b1;
    rst_n = 1'b0;
    tick();
    check("rstpulse_locked",   mon.locked,       0);
    check("rstpulse_period",   mon.period,       0);
    check("rstpulse_pv",       mon.period_valid, 0);
    check("rstpulse_clk_lost", mon.clk_lost,     0);
    check("rstpulse_state",    dut.state_q,      ST_IDLE);
    rst_n = 1'b1;
    clear_log();
    base = sidx + 1;
    run_period(3, 4);
    run_period(4, 4);
    run_period(4, 4);
    check("postrst_rise_idx",     first_rise - base, 3);
    check("postrst_pv_at_rise",   pv_at_first_rise,  0);
    check("postrst_first_period", first_pv_period,   7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flop count on clk_slow, minimum 2.
REQ-002 Parameter CNT_W, default 16: width of the period counter and the period output.
REQ-003 Parameter TIMEOUT, default 1024: clkin cycles without a rising edge before clk_slow is declared lost.
REQ-004 Parameter LOCK_COUNT, default 4: consecutive in-tolerance periods required to assert locked.
REQ-005 Parameter TOL, default 1: maximum absolute difference between consecutive periods still counted as in-tolerance.
REQ-006 Port clkin  input  1  system clock; all logic is clocked on its rising edge.
REQ-007 Port rst_n  input  1  reset, synchronous and active-low.
REQ-008 Port clk_slow  input  1  divided or external slow clock, asynchronous to clkin.
REQ-009 Port rise_tick  output  1  one-cycle strobe on each synchronized rising edge of clk_slow.
REQ-010 Port fall_tick  output  1  one-cycle strobe on each synchronized falling edge of clk_slow.
REQ-011 Port period  output  CNT_W  clkin cycles between the last two rise_ticks.
REQ-012 Port period_valid  output  1  one-cycle strobe when period is updated.
REQ-013 Port locked  output  1  level; clk_slow period is stable.
REQ-014 Port clk_lost  output  1  level; no rising edge seen for TIMEOUT cycles.

Function
REQ-015 clk_slow SHALL pass through SYNC_STAGES flops and then one edge-history flop.
REQ-016 rise_tick SHALL assert exactly SYNC_STAGES+1 cycles after the first clkin edge that samples clk_slow high following a low sample; fall_tick follows the same rule for a high-to-low transition.
REQ-017 A free-running counter cnt SHALL reset to 1 on each rise_tick, increment otherwise, and saturate at 2^CNT_W-1.
REQ-018 On each rise_tick after the first one following reset or recovery, period SHALL load cnt and period_valid SHALL pulse in the same cycle.
REQ-019 The FSM SHALL have four states: IDLE, MEASURE, LOCKED and LOST.
REQ-020 IDLE SHALL move to MEASURE on the first rise_tick; that rise_tick SHALL produce no period_valid.
REQ-021 In MEASURE, each period_valid with |period_new - period_prev| <= TOL SHALL increment match_cnt; an out-of-tolerance period SHALL clear match_cnt to 0.
REQ-022 MEASURE SHALL move to LOCKED in the cycle after match_cnt reaches LOCK_COUNT; locked SHALL be high exactly while the FSM is in LOCKED.
REQ-023 LOCKED SHALL return to MEASURE with match_cnt = 0 on any out-of-tolerance period.
REQ-024 Any state except LOST SHALL move to LOST when cnt reaches TIMEOUT without a rise_tick; clk_lost SHALL be high exactly while the FSM is in LOST.
REQ-025 In LOST, cnt SHALL hold and match_cnt SHALL be 0; the next rise_tick SHALL move the FSM to MEASURE and behave as the first rise_tick, with no period_valid.
REQ-026 If the timeout and a rise_tick occur in the same cycle, the rise_tick SHALL win and LOST SHALL NOT be entered.
REQ-027 The first period comparison after entering MEASURE SHALL compare against the reset value of period_prev (0), so it counts as a mismatch unless the period is <= TOL.

Reset
REQ-028 While rst_n is low at a clkin edge: FSM goes to IDLE; synchronizer and history flops go to 0; cnt, period, period_prev and match_cnt go to 0; all strobes, locked and clk_lost go to 0.
REQ-029 Reset asserted mid-operation SHALL take effect at the next clkin edge, with no partial measurement retained.

Structure
REQ-030 FSM state encoding and the default parameter constants SHALL live in the shared project package.
REQ-031 The synchronizer and edge detector SHALL be a sub-module, sync_edge, with ports clkin, rst_n, din, rise and fall.

Verification
REQ-032 clk_slow = clkin/2: period_valid every 2 cycles with period = 2; locked high after 5 period_valids.
REQ-033 clk_slow = clkin/8: period = 8; locked asserts; then switching to clkin/16 drops locked on the first period = 16, which relocks later.
REQ-034 Stop clk_slow with TIMEOUT = 64: clk_lost rises 64 cycles after the last rise_tick; on restart, the first rise_tick clears clk_lost and produces no period_valid.
REQ-035 Alternate periods 8 and 9 with TOL = 1: locked asserts; alternate 8 and 11: locked never asserts.
REQ-036 Pulse rst_n low for 1 cycle while LOCKED: next cycle locked = 0, period = 0, FSM in IDLE.
